gty_refclk_freq_monitor: RTL and testbench

//  Measures the frequency of each GTY reference clock against the free-running system clock.

---
 rtl/gty_refclk_mon_pkg.sv | 33 +++
 rtl/gty_refclk_freq_monitor_if.sv | 13 +
 rtl/gty_refclk_gray_cnt.sv | 59 +++++
 rtl/gty_refclk_freq_monitor.sv | 102 ++++++++++
 tb/tb_gty_refclk_freq_monitor.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/gty_refclk_mon_pkg.sv
// Shared widths and Gray/field helpers for the GTY refclk frequency monitor.
// Helpers work on zero-extended words up to GRAY_MAX_W bits, so any CNT_W <= GRAY_MAX_W fits.
package gty_refclk_mon_pkg;

  localparam int CNT_W_DEFAULT = 24;
  localparam int GRAY_MAX_W    = 32;
  localparam int MAX_CHANNELS  = 16;
  localparam int FIELD_BUS_W   = MAX_CHANNELS * GRAY_MAX_W;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Upper zero bits leave the lower bits unchanged, which is what makes this width-agnostic.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic gray_word_t freq_field(input logic [FIELD_BUS_W-1:0] bus,
                                            input int n, input int w);
    logic [FIELD_BUS_W-1:0] shifted;
    shifted = bus >> (n * w);
    return gray_word_t'(shifted) & ((gray_word_t'(1) << w) - gray_word_t'(1));
  endfunction

endpackage

// File: rtl/gty_refclk_freq_monitor_if.sv
// Result bus of the refclk frequency monitor; master drives, slave observes.
interface gty_refclk_freq_monitor_if #(
  parameter int NUM_REFCLK = 4,
  parameter int CNT_W      = 24
);
  logic [NUM_REFCLK*CNT_W-1:0] freq_count_o;
  logic                        freq_valid_o;
  logic [NUM_REFCLK-1:0]       clk_absent_o;
  logic [NUM_REFCLK-1:0]       freq_ok_o;

  modport master (output freq_count_o, freq_valid_o, clk_absent_o, freq_ok_o);
  modport slave  (input  freq_count_o, freq_valid_o, clk_absent_o, freq_ok_o);
endinterface

// File: rtl/gty_refclk_gray_cnt.sv
// One refclk channel: free-running counter in the refclk domain, Gray-coded across to clk.
// Valid only while f(i_refclk) < f(clk), so every Gray value is seen by at least one clk edge.
module gty_refclk_gray_cnt
  import gty_refclk_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_refclk,
  output logic [CNT_W-1:0] o_count
);

  (* ASYNC_REG = "TRUE" *) logic [1:0] r_rst_sync;
  logic             w_ref_rst;
  logic [CNT_W-1:0] r_bin;
  logic [CNT_W-1:0] w_bin_next;
  logic [CNT_W-1:0] r_gray;
  (* ASYNC_REG = "TRUE" *) logic [CNT_W-1:0] r_gray_meta;
  (* ASYNC_REG = "TRUE" *) logic [CNT_W-1:0] r_gray_sync;
  logic [CNT_W-1:0] r_count;

  // Reset asserts at once; release waits two refclk edges so the counter leaves reset cleanly.
  always_ff @(posedge i_refclk or posedge rst) begin
    if (rst) begin
      r_rst_sync <= 2'b11;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b0};
    end
  end

  assign w_ref_rst  = r_rst_sync[1];
  assign w_bin_next = r_bin + CNT_W'(1);

  always_ff @(posedge i_refclk or posedge w_ref_rst) begin
    if (w_ref_rst) begin
      r_bin  <= '0;
      r_gray <= '0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= CNT_W'(bin2gray(GRAY_MAX_W'(w_bin_next)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gray_meta <= '0;
      r_gray_sync <= '0;
      r_count     <= '0;
    end else begin
      r_gray_meta <= r_gray;
      r_gray_sync <= r_gray_meta;
      r_count     <= CNT_W'(gray2bin(GRAY_MAX_W'(r_gray_sync)));
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/gty_refclk_freq_monitor.sv
// Per-window edge count, absent flag and range check for each GTY refclk, timed by clk.
// Build option REFCLK_FREQ_LIMITS_EN adds the FREQ_MIN/FREQ_MAX comparators; otherwise ok = present.
module gty_refclk_freq_monitor
  import gty_refclk_mon_pkg::*;
#(
  parameter int NUM_REFCLK  = 4,
  parameter int GATE_CYCLES = 300000,
  parameter int CNT_W       = CNT_W_DEFAULT
`ifdef REFCLK_FREQ_LIMITS_EN
  ,
  parameter int FREQ_MIN    = 80000,
  parameter int FREQ_MAX    = 81100
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REFCLK-1:0] refclk_i,
  gty_refclk_freq_monitor_if.master mon
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  logic [GATE_W-1:0]     r_gate;
  logic                  r_first;
  logic                  r_valid;
  logic                  w_tc;
  logic [CNT_W-1:0]      w_sync     [NUM_REFCLK];
  logic [CNT_W-1:0]      w_delta    [NUM_REFCLK];
  logic [CNT_W-1:0]      r_baseline [NUM_REFCLK];
  logic [CNT_W-1:0]      r_count    [NUM_REFCLK];
  logic [NUM_REFCLK-1:0] w_absent;
  logic [NUM_REFCLK-1:0] w_ok;
  logic [NUM_REFCLK-1:0] r_absent;
  logic [NUM_REFCLK-1:0] r_ok;

  generate
    for (genvar gi = 0; gi < NUM_REFCLK; gi++) begin : g_ch
      gty_refclk_gray_cnt #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_refclk (refclk_i[gi]),
        .o_count  (w_sync[gi])
      );

      // Modulo subtraction makes counter wrap within a window invisible.
      assign w_delta[gi]  = w_sync[gi] - r_baseline[gi];
      assign w_absent[gi] = (w_delta[gi] == '0);
`ifdef REFCLK_FREQ_LIMITS_EN
      assign w_ok[gi] = ~w_absent[gi] &&
                        (w_delta[gi] >= CNT_W'(FREQ_MIN)) &&
                        (w_delta[gi] <= CNT_W'(FREQ_MAX));
`else
      assign w_ok[gi] = ~w_absent[gi];
`endif
      assign mon.freq_count_o[gi*CNT_W +: CNT_W] = r_count[gi];
    end
  endgenerate

  assign w_tc = (r_gate == GATE_LAST);

  // The first terminal count only seeds the baseline; its delta is meaningless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gate   <= '0;
      r_first  <= 1'b1;
      r_valid  <= 1'b0;
      r_absent <= '0;
      r_ok     <= '0;
      for (int n = 0; n < NUM_REFCLK; n++) begin
        r_baseline[n] <= '0;
        r_count[n]    <= '0;
      end
    end else begin
      r_valid <= 1'b0;
      if (w_tc) begin
        r_gate  <= '0;
        r_first <= 1'b0;
        for (int n = 0; n < NUM_REFCLK; n++) begin
          r_baseline[n] <= w_sync[n];
        end
        if (!r_first) begin
          r_valid  <= 1'b1;
          r_absent <= w_absent;
          r_ok     <= w_ok;
          for (int n = 0; n < NUM_REFCLK; n++) begin
            r_count[n] <= w_delta[n];
          end
        end
      end else begin
        r_gate <= r_gate + GATE_W'(1);
      end
    end
  end

  assign mon.freq_valid_o = r_valid;
  assign mon.clk_absent_o = r_absent;
  assign mon.freq_ok_o    = r_ok;

endmodule

// File: tb/tb_gty_refclk_freq_monitor.sv
// Bench for gty_refclk_freq_monitor: 4-channel 24-bit DUT plus a 1-channel 8-bit DUT on refclk 0.
// Expected counts come from window time x refclk frequency; REFCLK_FREQ_LIMITS_EN selects the ok rule.
`timescale 1ns/1ps
module tb_gty_refclk_freq_monitor;

  localparam int  NCH    = 4;
  localparam int  GC     = 1000;
  localparam int  CW     = 24;
  localparam int  CW8    = 8;
  localparam real WIN_NS = GC * 10.0;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] refclk;
  real            half_ns [NCH];
  bit             en      [NCH];
  int             n_checks = 0;
  int             n_pass   = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ref
      logic rc = 1'b0;
      initial begin
        forever begin
          if (en[gi]) begin
            #(half_ns[gi]);
            rc = ~rc;
          end else begin
            rc = 1'b0;
            #1;
          end
        end
      end
      assign refclk[gi] = rc;
    end
  endgenerate

  gty_refclk_freq_monitor_if #(.NUM_REFCLK(NCH), .CNT_W(CW)) mon_if ();
  gty_refclk_freq_monitor_if #(.NUM_REFCLK(1), .CNT_W(CW8)) mon8_if ();

  gty_refclk_freq_monitor #(
    .NUM_REFCLK  (NCH),
    .GATE_CYCLES (GC),
    .CNT_W       (CW)
`ifdef REFCLK_FREQ_LIMITS_EN
    ,
    .FREQ_MIN    (390),
    .FREQ_MAX    (410)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .refclk_i (refclk),
    .mon      (mon_if)
  );

  gty_refclk_freq_monitor #(
    .NUM_REFCLK  (1),
    .GATE_CYCLES (GC),
    .CNT_W       (CW8)
`ifdef REFCLK_FREQ_LIMITS_EN
    ,
    .FREQ_MIN    (100),
    .FREQ_MAX    (200)
`endif
  ) dut8 (
    .clk      (clk),
    .rst      (rst),
    .refclk_i (refclk[0]),
    .mon      (mon8_if)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic chk_near(input string tag, input int obs, input int lo, input int hi);
    n_checks++;
    assert ((obs >= lo && obs <= hi) === 1'b1) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d..%0d", tag, obs, lo, hi);
  endtask

  // Edges in one window = window length / refclk period.
  function automatic int exp_count(input int ch);
    if (!en[ch]) return 0;
    return $rtoi(WIN_NS / (2.0 * half_ns[ch]) + 0.5);
  endfunction

  function automatic int exp_ok(input int c, input int lo, input int hi);
`ifdef REFCLK_FREQ_LIMITS_EN
    return int'(c >= lo && c <= hi);
`else
    return int'(c != 0 && lo <= hi);
`endif
  endfunction

  task automatic set_freq(input int ch, input real mhz);
    half_ns[ch] = $floor(500.0 / mhz * 1000.0 + 0.5) / 1000.0;
    en[ch]      = 1'b1;
  endtask

  function automatic int cnt_of(input int ch);
    return int'(mon_if.freq_count_o[ch*CW +: CW]);
  endfunction

  task automatic wait_valid(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (mon_if.freq_valid_o !== 1'b1 && cycles < 3 * GC);
  endtask

  task automatic check_window(input string tag);
    int e, e8, o8;
    $display("window %s: cnt=%0d/%0d/%0d/%0d absent=%b ok=%b cnt8=%0d", tag,
             cnt_of(0), cnt_of(1), cnt_of(2), cnt_of(3),
             mon_if.clk_absent_o, mon_if.freq_ok_o, int'(mon8_if.freq_count_o));
    for (int ch = 0; ch < NCH; ch++) begin
      e = exp_count(ch);
      if (e == 0) chk($sformatf("%s_ch%0d_count", tag, ch), cnt_of(ch), 0);
      else        chk_near($sformatf("%s_ch%0d_count", tag, ch), cnt_of(ch), e - 1, e + 1);
      chk($sformatf("%s_ch%0d_absent", tag, ch), int'(mon_if.clk_absent_o[ch]), int'(e == 0));
      chk($sformatf("%s_ch%0d_ok", tag, ch), int'(mon_if.freq_ok_o[ch]), exp_ok(e, 390, 410));
    end
    e8 = exp_count(0) % 256;
    o8 = int'(mon8_if.freq_count_o);
    chk($sformatf("%s_w8_valid", tag), int'(mon8_if.freq_valid_o), 1);
    if (e8 == 0) chk($sformatf("%s_w8_count", tag), o8, 0);
    else         chk_near($sformatf("%s_w8_count", tag), o8, e8 - 1, e8 + 1);
    chk($sformatf("%s_w8_absent", tag), int'(mon8_if.clk_absent_o), int'(e8 == 0));
    if (e8 < 98 || (e8 > 102 && e8 < 198) || e8 > 202)
      chk($sformatf("%s_w8_ok", tag), int'(mon8_if.freq_ok_o), exp_ok(e8, 100, 200));
  endtask

  task automatic check_cleared(input string tag);
    for (int ch = 0; ch < NCH; ch++) chk($sformatf("%s_ch%0d_count", tag, ch), cnt_of(ch), 0);
    chk({tag, "_valid"},  int'(mon_if.freq_valid_o), 0);
    chk({tag, "_absent"}, int'(mon_if.clk_absent_o), 0);
    chk({tag, "_ok"},     int'(mon_if.freq_ok_o), 0);
    chk({tag, "_w8_count"}, int'(mon8_if.freq_count_o), 0);
  endtask

  initial begin
    int cyc;
    int c;
    for (int ch = 0; ch < NCH; ch++) set_freq(ch, 40.0);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_cleared("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    wait_valid(cyc);
    chk("first_pulse_latency", cyc, 2 * GC);
    check_window("all40");
    @(posedge clk);
    #1;
    chk("valid_one_cycle", int'(mon_if.freq_valid_o), 0);
    wait_valid(cyc);
    chk("period_a", cyc, GC - 1);
    check_window("all40_b");

    en[2] = 1'b0;
    wait_valid(cyc);
    wait_valid(cyc);
    chk("period_b", cyc, GC);
    check_window("ch2_absent");
    set_freq(2, 40.0);
    wait_valid(cyc);
    wait_valid(cyc);
    check_window("ch2_back");

    set_freq(1, 45.0);
    wait_valid(cyc);
    wait_valid(cyc);
    check_window("ch1_45");

    repeat (GC / 2) @(posedge clk);
    set_freq(0, 38.0);
    wait_valid(cyc);
    chk_near("ch0_step_intermediate", cnt_of(0), 379, 401);
    wait_valid(cyc);
    check_window("ch0_38");

    for (int r = 0; r < 6; r++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if ($urandom_range(0, 4) == 0) begin
          en[ch] = 1'b0;
        end else begin
          do c = int'($urandom_range(340, 480)); while (c >= 386 && c <= 414 && $urandom_range(0, 1) == 0);
          if (c >= 386 && c <= 414) c = 400;
          set_freq(ch, real'(c) / 10.0);
        end
      end
      wait_valid(cyc);
      wait_valid(cyc);
      chk($sformatf("rand%0d_period", r), cyc, GC);
      check_window($sformatf("rand%0d", r));
    end

    repeat (600) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_cleared("midrst");
    for (int ch = 0; ch < NCH; ch++) set_freq(ch, 40.0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_valid(cyc);
    chk("midrst_first_pulse_latency", cyc, 2 * GC);
    check_window("after_midrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
